pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MA, MA/WB registers).
- Per cycle, generates stall, flush and forwarding selects for the pipeline registers and PC.
- Detects load-use hazards and branch/jump redirects resolved in MA.
- Freezes the whole pipeline while data memory is not ready, with a timeout watchdog FSM.
- Flush outputs drive the pipeline registers' synchronous flush inputs.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before a memory error is declared.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clkIn  input  1  pipeline clock
- resetIn  input  1  asynchronous reset, active-high
- idRsIn / idRtIn  input  5 each  source registers of the instruction in ID
- idUsesRsIn / idUsesRtIn  input  1 each  ID instruction actually reads rs / rt
- exRsIn / exRtIn  input  5 each  source registers of the instruction in EX
- exMemReadIn  input  1  EX instruction is a load
- exRegWriteIn  input  1  EX instruction writes the register file
- exRdIn  input  5  EX destination register
- maRegWriteIn / maRdIn  input  1 / 5  MA write enable and destination
- wbRegWriteIn / wbRdIn  input  1 / 5  WB write enable and destination
- redirectIn  input  1  branch taken or jump, resolved in MA
- memReqIn  input  1  MA instruction accesses data memory
- memReadyIn  input  1  data memory completes the access this cycle
- pcStallOut  output  1  hold PC
- ifidStallOut  output  1  hold IF/ID
- idexStallOut / exmaStallOut / mawbStallOut  output  1 each  hold the respective register
- ifidFlushOut / idexFlushOut / exmaFlushOut  output  1 each  bubble the respective register
- fwdAOut / fwdBOut  output  2 each  EX operand source: 00 regfile, 01 EX/MA result, 10 MA/WB result
- memErrOut  output  1  sticky memory timeout error
- stateOut  output  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 ERROR

Behaviour:
- Reset (async, active-high): state is RUN, wait counter 0, memErrOut 0. All stall/flush outputs are forced to 0 and forwarding outputs to 00 while resetIn is high.
- freeze = (memReqIn & ~memReadyIn) | (state == ERROR), combinational.
  - When freeze is 1: all five stall outputs are 1 and all flushes are 0.
  - Freeze has top priority.
- Redirect, when not frozen and redirectIn = 1:
  - ifidFlushOut, idexFlushOut and exmaFlushOut are 1.
  - Stall outputs are 0, so PC loads the target.
  - Overrides load-use.
- Load-use, when not frozen and no redirect:
  - Condition: exMemReadIn & exRegWriteIn & exRdIn != 0 & ((idUsesRsIn & idRsIn == exRdIn) | (idUsesRtIn & idRtIn == exRdIn)).
  - Response: pcStallOut = 1, ifidStallOut = 1, idexFlushOut = 1. Exactly one bubble is inserted.
- Forwarding (fwdAOut shown; fwdBOut identical using exRtIn):
  - 01 if maRegWriteIn & maRdIn != 0 & maRdIn == exRsIn.
  - Else 10 if wbRegWriteIn & wbRdIn != 0 & wbRdIn == exRsIn.
  - Else 00.
  - MA has priority over WB. Register 0 never forwards.
  - Forwarding outputs stay valid during freeze.
- FSM (registered, on clkIn rising edge):
  - RUN: if memReqIn & ~memReadyIn, go to MEM_WAIT with counter = 1.
  - MEM_WAIT:
    - memReadyIn = 1 or memReqIn = 0: go to RUN, counter 0.
    - Otherwise, counter == MEM_TIMEOUT: go to ERROR, memErrOut set to 1.
    - Otherwise counter increments.
  - ERROR: absorbing. memErrOut and freeze hold until reset.
- A redirect arriving during freeze is not acted on. Because MA is held, redirectIn remains asserted and the flush occurs in the first unfrozen cycle.
- memReadyIn = 1 in the first request cycle: no freeze, no state change.
- Latency: all stall/flush/forward outputs are combinational, same cycle as their inputs. State and memErrOut are registered with 1-cycle latency.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stallCntOut[31:0], flushCntOut[31:0] and loadUseCntOut[31:0]. They are free-running saturating counters that increment on cycles with freeze, with redirect flush, and with load-use bubble respectively. They clear on reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `pipe_ctrl_pkg`: FSM state encoding (RUN, MEM_WAIT, ERROR) and forward-select constants FWD_REG = 00, FWD_MA = 01, FWD_WB = 10.
- One natural sub-module, `fwd_sel`: pure combinational operand-source select, instantiated twice (operands A and B).

Test Plan:
- Load-use: EX load with exRdIn = 5, ID add with idRsIn = 5 and idUsesRsIn = 1 -> pcStallOut = ifidStallOut = idexFlushOut = 1 for exactly 1 cycle. With exRdIn = 0 -> no stall.
- Forwarding: maRdIn = wbRdIn = exRsIn = 7, both write enables set -> fwdAOut = 01. Clear maRegWriteIn -> 10. exRtIn = 0 -> fwdBOut = 00.
- Redirect with simultaneous load-use -> only ifid/idex/exma flush = 1, all stalls 0.
- Memory wait: memReqIn = 1, memReadyIn = 0 for 3 cycles, then 1 -> all stalls 1 for 3 cycles, stateOut 01, then 00. A redirect held throughout flushes in the cycle memReadyIn = 1.
- Timeout: memReadyIn held at 0 for 16 cycles -> stateOut = 10, memErrOut = 1, all stalls held. Assert resetIn mid-ERROR -> all outputs 0 immediately (asynchronous), stateOut = 00.
- HAZARD_PERF_EN: 2 load-use bubbles and 1 redirect -> loadUseCntOut = 2, flushCntOut = 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrlState_e : watchdog FSM state encoding, which is also the stateOut encoding
//   FWD_*       : EX operand source selects driven on fwdAOut / fwdBOut
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StError   = 2'b10
  } ctrlState_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MA  = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Operand source select for one EX operand. Purely combinational.
// Ports:
//   exRegIn              source register read by the EX instruction
//   maRegWriteIn/maRdIn  MA stage write enable and destination
//   wbRegWriteIn/wbRdIn  WB stage write enable and destination
//   selOut               FWD_REG / FWD_MA / FWD_WB
// The younger result in MA wins over WB, and r0 is never forwarded.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] exRegIn,
  input  logic       maRegWriteIn,
  input  logic [4:0] maRdIn,
  input  logic       wbRegWriteIn,
  input  logic [4:0] wbRdIn,
  output logic [1:0] selOut
);

  always_comb begin
    selOut = FWD_REG;
    if (maRegWriteIn && (maRdIn != 5'd0) && (maRdIn == exRegIn)) begin
      selOut = FWD_MA;
    end else if (wbRegWriteIn && (wbRdIn != 5'd0) && (wbRdIn == exRegIn)) begin
      selOut = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline.
// Ports:
//   clkIn, resetIn            clock, asynchronous active-high reset
//   id*/ex*/ma*/wb* inputs    register ids and write enables of the stages
//   redirectIn                taken branch / jump resolved in MA
//   memReqIn, memReadyIn      data memory handshake of the MA instruction
//   *StallOut                 hold PC / pipeline registers
//   *FlushOut                 bubble pipeline registers (synchronous flush)
//   fwdAOut, fwdBOut          EX operand source selects
//   memErrOut                 sticky memory timeout error
//   stateOut                  watchdog FSM state (00 RUN, 01 MEM_WAIT, 10 ERROR)
// Optional: define HAZARD_PERF_EN to add saturating event counters
//   stallCntOut (freeze cycles), flushCntOut (redirect flushes),
//   loadUseCntOut (load-use bubbles).
// Priority of the per-cycle response: freeze > redirect > load-use.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [4:0]  idRsIn,
  input  logic [4:0]  idRtIn,
  input  logic        idUsesRsIn,
  input  logic        idUsesRtIn,
  input  logic [4:0]  exRsIn,
  input  logic [4:0]  exRtIn,
  input  logic        exMemReadIn,
  input  logic        exRegWriteIn,
  input  logic [4:0]  exRdIn,
  input  logic        maRegWriteIn,
  input  logic [4:0]  maRdIn,
  input  logic        wbRegWriteIn,
  input  logic [4:0]  wbRdIn,
  input  logic        redirectIn,
  input  logic        memReqIn,
  input  logic        memReadyIn,
  output logic        pcStallOut,
  output logic        ifidStallOut,
  output logic        idexStallOut,
  output logic        exmaStallOut,
  output logic        mawbStallOut,
  output logic        ifidFlushOut,
  output logic        idexFlushOut,
  output logic        exmaFlushOut,
  output logic [1:0]  fwdAOut,
  output logic [1:0]  fwdBOut,
  output logic        memErrOut,
  output logic [1:0]  stateOut
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stallCntOut,
  output logic [31:0] flushCntOut,
  output logic [31:0] loadUseCntOut
`endif
);

  ctrlState_e       stateQ, stateD;
  logic [CNT_W-1:0] waitCntQ, waitCntD;
  logic             memStall, freeze, loadUse, flushEvent, loadUseEvent;
  logic [1:0]       fwdASel, fwdBSel;

  assign memStall = memReqIn & ~memReadyIn;
  assign freeze   = memStall | (stateQ == StError);

  assign loadUse = exMemReadIn & exRegWriteIn & (exRdIn != 5'd0) &
                   ((idUsesRsIn & (idRsIn == exRdIn)) | (idUsesRtIn & (idRtIn == exRdIn)));

  // A redirect seen while frozen is simply deferred: MA is held, so redirectIn
  // is still asserted in the first unfrozen cycle.
  assign flushEvent   = ~freeze & redirectIn;
  assign loadUseEvent = ~freeze & ~redirectIn & loadUse;

  always_comb begin
    pcStallOut   = 1'b0;
    ifidStallOut = 1'b0;
    idexStallOut = 1'b0;
    exmaStallOut = 1'b0;
    mawbStallOut = 1'b0;
    ifidFlushOut = 1'b0;
    idexFlushOut = 1'b0;
    exmaFlushOut = 1'b0;
    if (!resetIn) begin
      if (freeze) begin
        pcStallOut   = 1'b1;
        ifidStallOut = 1'b1;
        idexStallOut = 1'b1;
        exmaStallOut = 1'b1;
        mawbStallOut = 1'b1;
      end else if (flushEvent) begin
        ifidFlushOut = 1'b1;
        idexFlushOut = 1'b1;
        exmaFlushOut = 1'b1;
      end else if (loadUseEvent) begin
        // Hold PC and IF/ID one cycle, bubble into EX.
        pcStallOut   = 1'b1;
        ifidStallOut = 1'b1;
        idexFlushOut = 1'b1;
      end
    end
  end

  fwd_sel uFwdA (
    .exRegIn      (exRsIn),
    .maRegWriteIn (maRegWriteIn),
    .maRdIn       (maRdIn),
    .wbRegWriteIn (wbRegWriteIn),
    .wbRdIn       (wbRdIn),
    .selOut       (fwdASel)
  );

  fwd_sel uFwdB (
    .exRegIn      (exRtIn),
    .maRegWriteIn (maRegWriteIn),
    .maRdIn       (maRdIn),
    .wbRegWriteIn (wbRegWriteIn),
    .wbRdIn       (wbRdIn),
    .selOut       (fwdBSel)
  );

  assign fwdAOut = resetIn ? FWD_REG : fwdASel;
  assign fwdBOut = resetIn ? FWD_REG : fwdBSel;

  // Memory watchdog: waitCntQ counts consecutive stalled cycles, the RUN cycle
  // that enters MEM_WAIT being the first.
  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    unique case (stateQ)
      StRun: begin
        if (memStall) begin
          stateD   = StMemWait;
          waitCntD = CNT_W'(1);
        end
      end
      StMemWait: begin
        if (memReadyIn || !memReqIn) begin
          stateD   = StRun;
          waitCntD = '0;
        end else if (waitCntQ == CNT_W'(MEM_TIMEOUT)) begin
          stateD = StError;
        end else begin
          waitCntD = waitCntQ + CNT_W'(1);
        end
      end
      StError: begin
        stateD = StError;
      end
      default: begin
        stateD   = StRun;
        waitCntD = '0;
      end
    endcase
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      stateQ   <= StRun;
      waitCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
    end
  end

  assign stateOut  = stateQ;
  assign memErrOut = (stateQ == StError);

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCntQ, flushCntQ, loadUseCntQ;

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      stallCntQ   <= '0;
      flushCntQ   <= '0;
      loadUseCntQ <= '0;
    end else begin
      if (freeze && (stallCntQ != '1)) begin
        stallCntQ <= stallCntQ + 32'd1;
      end
      if (flushEvent && (flushCntQ != '1)) begin
        flushCntQ <= flushCntQ + 32'd1;
      end
      if (loadUseEvent && (loadUseCntQ != '1)) begin
        loadUseCntQ <= loadUseCntQ + 32'd1;
      end
    end
  end

  assign stallCntOut   = stallCntQ;
  assign flushCntOut   = flushCntQ;
  assign loadUseCntOut = loadUseCntQ;
`endif

endmodule
